// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM period, high time and 0..255 duty cycle of an asynchronous input
module pwm_capture #(
    parameter int CNT_LENGTH     = 32,
    parameter int WORD_LENGTH    = 8,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   pwm_in,
    output logic [CNT_LENGTH-1:0]  period_cycles,
    output logic [CNT_LENGTH-1:0]  high_cycles,
    output logic [WORD_LENGTH-1:0] duty_cycle,
    output logic                   meas_valid,
    output logic                   busy,
    output logic                   stuck
);
    localparam int DW = CNT_LENGTH + WORD_LENGTH;
    localparam int IW = $clog2(WORD_LENGTH + 1);
    localparam logic [DW-1:0]         FULL        = DW'((1 << WORD_LENGTH) - 1);
    localparam logic [CNT_LENGTH-1:0] TIMEOUT_VAL = CNT_LENGTH'(TIMEOUT_CYCLES);
    localparam logic [IW-1:0]         LAST_ITER   = IW'(WORD_LENGTH - 1);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t                 state, state_nxt;
    logic                   sync_0, s, s_d;
    logic                   rise_evt, capture, start, timeout, div_done, q_bit;
    logic [CNT_LENGTH-1:0]  period_cnt, high_cnt, cap_period, cap_high;
    logic [DW-1:0]          rem, dvs;
    logic [WORD_LENGTH-2:0] quo;
    logic [IW-1:0]          iter;

    assign rise_evt = s & ~s_d;

    // Two-flop synchronizer plus a delay flop for rising-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_0 <= 1'b0;
            s      <= 1'b0;
            s_d    <= 1'b0;
        end else begin
            sync_0 <= pwm_in;
            s      <= sync_0;
            s_d    <= s;
        end
    end

    // Measurement state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Event decode and next state; enable beats edges, edges beat timeout
    always_comb begin
        capture   = enable && state == MEASURE && rise_evt;
        start     = capture && !busy;
        timeout   = enable && state == MEASURE && !rise_evt && period_cnt == TIMEOUT_VAL;
        q_bit     = rem >= dvs;
        div_done  = enable && !timeout && busy && iter == LAST_ITER;
        state_nxt = !enable ? IDLE :
                    (state == IDLE && rise_evt) ? MEASURE :
                    timeout ? IDLE : state;
    end

    // Period and high counters: restart at 1/1 on each accepted edge, saturate otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_cnt <= '0;
            high_cnt   <= '0;
        end else if (state_nxt == MEASURE && rise_evt) begin
            period_cnt <= CNT_LENGTH'(1);
            high_cnt   <= CNT_LENGTH'(1);
        end else if (state_nxt == IDLE) begin
            period_cnt <= '0;
            high_cnt   <= '0;
        end else begin
            if (period_cnt != '1) period_cnt <= period_cnt + 1'b1;
            if (s && high_cnt != '1) high_cnt <= high_cnt + 1'b1;
        end
    end

    // Restoring divider: one quotient bit per cycle, divisor pre-shifted to the MSB position
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy       <= 1'b0;
            iter       <= '0;
            rem        <= '0;
            dvs        <= '0;
            quo        <= '0;
            cap_period <= '0;
            cap_high   <= '0;
        end else if (!enable || timeout) begin
            busy <= 1'b0;
        end else if (start) begin
            cap_period <= period_cnt;
            cap_high   <= high_cnt;
            rem        <= DW'(high_cnt) * FULL;
            dvs        <= DW'(period_cnt) << (WORD_LENGTH - 1);
            quo        <= '0;
            iter       <= '0;
            busy       <= 1'b1;
        end else if (busy) begin
            if (q_bit) rem <= rem - dvs;
            dvs  <= dvs >> 1;
            quo  <= (WORD_LENGTH-1)'({quo, q_bit});
            iter <= iter + 1'b1;
            busy <= iter != LAST_ITER;
        end
    end

    // Result registers: updated together with the meas_valid pulse, held otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_cycles <= '0;
            high_cycles   <= '0;
            duty_cycle    <= '0;
            meas_valid    <= 1'b0;
            stuck         <= 1'b0;
        end else begin
            meas_valid <= timeout || div_done;
            if (timeout) begin
                period_cycles <= '0;
                high_cycles   <= '0;
                duty_cycle    <= {WORD_LENGTH{s}};
                stuck         <= 1'b1;
            end else begin
                if (div_done) begin
                    period_cycles <= cap_period;
                    high_cycles   <= cap_high;
                    duty_cycle    <= {quo, q_bit};
                end
                if (enable && rise_evt) stuck <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized and directed checks of pwm_capture against an edge-list model
`timescale 1ns/1ps
module tb_pwm_capture;
    localparam int T = 1500;
    localparam int W = 8;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] p;
        logic [31:0] h;
        logic [7:0]  d;
        logic        st;
    } ev_t;

    logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, pwm_in = 1'b0;
    logic [31:0] period_cycles, high_cycles;
    logic [7:0]  duty_cycle;
    logic        meas_valid, busy, stuck;

    int   cyc = 0;
    int   tests = 0, fails = 0;
    int   per_p[$], per_h[$], rise_cyc[$];
    ev_t  mv_q[$], exp_q[$];

    pwm_capture #(.CNT_LENGTH(32), .WORD_LENGTH(W), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwm_in),
        .period_cycles(period_cycles), .high_cycles(high_cycles), .duty_cycle(duty_cycle),
        .meas_valid(meas_valid), .busy(busy), .stuck(stuck)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        if (meas_valid) mv_q.push_back({32'(cyc), period_cycles, high_cycles, duty_cycle, stuck});

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic restart();
        enable = 1'b0;
        pwm_in = 1'b0;
        tick(3);
        enable = 1'b1;
        tick(3);
    endtask

    // Drives one rising edge per listed period, then a closing edge
    task automatic play();
        mv_q.delete();
        rise_cyc.delete();
        foreach (per_p[i]) begin
            pwm_in = 1'b1;
            rise_cyc.push_back(cyc);
            tick(per_h[i]);
            pwm_in = 1'b0;
            tick(per_p[i] - per_h[i]);
        end
        pwm_in = 1'b1;
        rise_cyc.push_back(cyc);
        tick(14);
    endtask

    // Model: every edge after the first closes a period; an edge is only measured if the
    // previous measured edge is at least W+1 cycles back; the result appears W+3 cycles after
    // the pin edge (2 sync cycles + edge cycle + W divide cycles)
    task automatic build_expected();
        int last;
        last = -1000;
        exp_q.delete();
        for (int i = 1; i < rise_cyc.size(); i++)
            if (rise_cyc[i] - last >= W + 1) begin
                last = rise_cyc[i];
                exp_q.push_back({32'(rise_cyc[i] + W + 3), 32'(per_p[i-1]), 32'(per_h[i-1]),
                                 8'(per_h[i-1] * 255 / per_p[i-1]), 1'b0});
            end
    endtask

    task automatic test_reset();
        tick(2);
        tests++;
        if ({period_cycles, high_cycles, duty_cycle, meas_valid, busy, stuck} !== '0) begin
            fails++;
            $display("FAIL reset_held: got p=%0d h=%0d d=%0d mv=%b busy=%b stuck=%b, expected all 0",
                     period_cycles, high_cycles, duty_cycle, meas_valid, busy, stuck);
        end
        reset = 1'b0;
        tick(3);
        tests++;
        if ({period_cycles, high_cycles, duty_cycle, meas_valid, busy, stuck} !== '0) begin
            fails++;
            $display("FAIL reset_release: got p=%0d h=%0d d=%0d mv=%b busy=%b stuck=%b, expected all 0",
                     period_cycles, high_cycles, duty_cycle, meas_valid, busy, stuck);
        end
    endtask

    task automatic test_basic();
        ev_t g;
        restart();
        per_p = {100, 100, 100, 100};
        per_h = {25, 25, 25, 25};
        play();
        build_expected();
        tests++;
        if (mv_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL basic count: got %0d expected %0d", mv_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            g = (i < mv_q.size()) ? mv_q[i] : '0;
            tests++;
            if (g !== exp_q[i]) begin
                fails++;
                $display("FAIL basic meas[%0d]: got cyc=%0d p=%0d h=%0d d=%0d st=%0d, expected cyc=%0d p=%0d h=%0d d=%0d st=%0d",
                         i, g.cyc, g.p, g.h, g.d, g.st, exp_q[i].cyc, exp_q[i].p, exp_q[i].h, exp_q[i].d, exp_q[i].st);
            end
        end
    endtask

    task automatic test_duty_change();
        ev_t g;
        restart();
        per_p = {1000, 1000, 1000, 1000, 1000};
        per_h = {500, 500, 500, 999, 999};
        play();
        build_expected();
        tests++;
        if (mv_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL duty_change count: got %0d expected %0d", mv_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            g = (i < mv_q.size()) ? mv_q[i] : '0;
            tests++;
            if (g !== exp_q[i]) begin
                fails++;
                $display("FAIL duty_change meas[%0d]: got cyc=%0d p=%0d h=%0d d=%0d, expected cyc=%0d p=%0d h=%0d d=%0d",
                         i, g.cyc, g.p, g.h, g.d, exp_q[i].cyc, exp_q[i].p, exp_q[i].h, exp_q[i].d);
            end
        end
    endtask

    task automatic test_stuck();
        int d0, d1;
        ev_t g;
        restart();
        mv_q.delete();
        pwm_in = 1'b1;
        d0 = cyc;
        tick(T + 10);
        g = (mv_q.size() > 0) ? mv_q[0] : '0;
        tests++;
        if (mv_q.size() != 1 || g !== {32'(d0 + T + 3), 32'd0, 32'd0, 8'd255, 1'b1}) begin
            fails++;
            $display("FAIL stuck_high: got n=%0d cyc=%0d p=%0d h=%0d d=%0d st=%0d, expected n=1 cyc=%0d p=0 h=0 d=255 st=1",
                     mv_q.size(), g.cyc, g.p, g.h, g.d, g.st, d0 + T + 3);
        end
        pwm_in = 1'b0;
        tick(5);
        mv_q.delete();
        pwm_in = 1'b1;
        d1 = cyc;
        tick(5);
        tests++;
        if (stuck !== 1'b0) begin
            fails++;
            $display("FAIL stuck_clear1: got stuck=%b expected 0", stuck);
        end
        pwm_in = 1'b0;
        tick(T + 10);
        g = (mv_q.size() > 0) ? mv_q[0] : '0;
        tests++;
        if (mv_q.size() != 1 || g !== {32'(d1 + T + 3), 32'd0, 32'd0, 8'd0, 1'b1}) begin
            fails++;
            $display("FAIL stuck_low: got n=%0d cyc=%0d p=%0d h=%0d d=%0d st=%0d, expected n=1 cyc=%0d p=0 h=0 d=0 st=1",
                     mv_q.size(), g.cyc, g.p, g.h, g.d, g.st, d1 + T + 3);
        end
        pwm_in = 1'b1;
        tick(5);
        tests++;
        if (stuck !== 1'b0) begin
            fails++;
            $display("FAIL stuck_clear2: got stuck=%b expected 0", stuck);
        end
    endtask

    task automatic test_decimation();
        ev_t g;
        restart();
        per_p = {5, 5, 5, 5, 5, 5, 5, 5};
        per_h = {2, 2, 2, 2, 2, 2, 2, 2};
        play();
        build_expected();
        tests++;
        if (mv_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL decimation count: got %0d expected %0d", mv_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            g = (i < mv_q.size()) ? mv_q[i] : '0;
            tests++;
            if (g !== exp_q[i]) begin
                fails++;
                $display("FAIL decimation meas[%0d]: got cyc=%0d p=%0d h=%0d d=%0d, expected cyc=%0d p=%0d h=%0d d=%0d",
                         i, g.cyc, g.p, g.h, g.d, exp_q[i].cyc, exp_q[i].p, exp_q[i].h, exp_q[i].d);
            end
        end
    endtask

    task automatic test_reset_mid_divide();
        ev_t g;
        restart();
        mv_q.delete();
        repeat (2) begin
            pwm_in = 1'b1;
            tick(7);
            pwm_in = 1'b0;
            tick(13);
        end
        pwm_in = 1'b1;
        tick(5);
        g = (mv_q.size() > 0) ? mv_q[0] : '0;
        tests++;
        if (mv_q.size() != 1 || g.p !== 32'd20 || g.h !== 32'd7 || g.d !== 8'd89 || busy !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset: got n=%0d p=%0d h=%0d d=%0d busy=%b, expected n=1 p=20 h=7 d=89 busy=1",
                     mv_q.size(), g.p, g.h, g.d, busy);
        end
        reset = 1'b1;
        tick(2);
        pwm_in = 1'b0;
        tick(3);
        tests++;
        if ({period_cycles, high_cycles, duty_cycle, meas_valid, busy, stuck} !== '0) begin
            fails++;
            $display("FAIL mid_divide_reset: got p=%0d h=%0d d=%0d mv=%b busy=%b, expected all 0",
                     period_cycles, high_cycles, duty_cycle, meas_valid, busy);
        end
        reset = 1'b0;
        tick(20);
        tests++;
        if (mv_q.size() != 1) begin
            fails++;
            $display("FAIL mid_divide_no_valid: got %0d results expected 1", mv_q.size());
        end
        per_p = {30, 30, 30};
        per_h = {12, 5, 29};
        play();
        build_expected();
        tests++;
        if (mv_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL resume count: got %0d expected %0d", mv_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            g = (i < mv_q.size()) ? mv_q[i] : '0;
            tests++;
            if (g !== exp_q[i]) begin
                fails++;
                $display("FAIL resume meas[%0d]: got cyc=%0d p=%0d h=%0d d=%0d, expected cyc=%0d p=%0d h=%0d d=%0d",
                         i, g.cyc, g.p, g.h, g.d, exp_q[i].cyc, exp_q[i].p, exp_q[i].h, exp_q[i].d);
            end
        end
    endtask

    task automatic test_enable();
        int r;
        ev_t g;
        restart();
        mv_q.delete();
        repeat (3) begin
            pwm_in = 1'b1;
            tick(10);
            pwm_in = 1'b0;
            tick(20);
        end
        pwm_in = 1'b1;
        tick(5);
        enable = 1'b0;
        tick(5);
        pwm_in = 1'b0;
        enable = 1'b1;
        tick(20);
        tests++;
        if (mv_q.size() != 2 || period_cycles !== 32'd30 || high_cycles !== 32'd10 || duty_cycle !== 8'd85) begin
            fails++;
            $display("FAIL enable_abort: got n=%0d p=%0d h=%0d d=%0d, expected n=2 p=30 h=10 d=85",
                     mv_q.size(), period_cycles, high_cycles, duty_cycle);
        end
        pwm_in = 1'b1;
        tick(10);
        pwm_in = 1'b0;
        tick(20);
        pwm_in = 1'b1;
        r = cyc;
        tick(14);
        g = (mv_q.size() > 2) ? mv_q[2] : '0;
        tests++;
        if (mv_q.size() != 3 || g !== {32'(r + W + 3), 32'd30, 32'd10, 8'd85, 1'b0}) begin
            fails++;
            $display("FAIL enable_resume: got n=%0d cyc=%0d p=%0d h=%0d d=%0d, expected n=3 cyc=%0d p=30 h=10 d=85",
                     mv_q.size(), g.cyc, g.p, g.h, g.d, r + W + 3);
        end
    endtask

    task automatic test_random();
        ev_t g;
        int p;
        for (int k = 0; k < 3; k++) begin
            restart();
            per_p.delete();
            per_h.delete();
            for (int i = 0; i < 12; i++) begin
                p = int'($urandom_range(60, 5));
                per_p.push_back(p);
                per_h.push_back(int'($urandom_range(p - 1, 1)));
            end
            play();
            build_expected();
            tests++;
            if (mv_q.size() != exp_q.size()) begin
                fails++;
                $display("FAIL random%0d count: got %0d expected %0d", k, mv_q.size(), exp_q.size());
            end
            foreach (exp_q[i]) begin
                g = (i < mv_q.size()) ? mv_q[i] : '0;
                tests++;
                if (g !== exp_q[i]) begin
                    fails++;
                    $display("FAIL random%0d meas[%0d]: got cyc=%0d p=%0d h=%0d d=%0d, expected cyc=%0d p=%0d h=%0d d=%0d",
                             k, i, g.cyc, g.p, g.h, g.d, exp_q[i].cyc, exp_q[i].p, exp_q[i].h, exp_q[i].d);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duty_change();
        test_stuck();
        test_decimation();
        test_reset_mid_divide();
        test_enable();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
